rbttx_phv_arbiter: RTL

- Upstream feeder of the reliable-send TX match-action stage.
- Merges two PHV streams into the single PHV stream the TX MAU consumes: freshly parsed packets ("new") and retransmission requests replayed by the retransmit engine ("rtx").
- Retransmissions take priority, with a starvation guard for new traffic.
- Every PHV is tagged with a retransmit flag. Registered output, one-cycle latency, full throughput.

---
 rtl/rbttx_phv_arbiter_if.sv | 33 +++
 rtl/rbttx_phv_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/rbttx_phv_arbiter_if.sv
// PHV handshake bundle between the two upstream PHV sources, the arbiter
// and the TX MAU. The "slave" modport is the arbiter's view: it accepts the
// new/rtx streams and drives the merged stream. The "master" modport is the
// surrounding environment's view.
interface rbttx_phv_arbiter_if #(
  parameter int PHV_WIDTH = 408
) ();
  logic                 s_new_phv_valid;
  logic                 s_new_phv_ready;
  logic [PHV_WIDTH-1:0] s_new_phv_info;
  logic                 s_rtx_phv_valid;
  logic                 s_rtx_phv_ready;
  logic [PHV_WIDTH-1:0] s_rtx_phv_info;
  logic                 m_phv_valid;
  logic                 m_phv_ready;
  logic [PHV_WIDTH-1:0] m_phv_info;

  modport slave (
    input  s_new_phv_valid, s_new_phv_info,
    input  s_rtx_phv_valid, s_rtx_phv_info,
    input  m_phv_ready,
    output s_new_phv_ready, s_rtx_phv_ready,
    output m_phv_valid, m_phv_info
  );

  modport master (
    output s_new_phv_valid, s_new_phv_info,
    output s_rtx_phv_valid, s_rtx_phv_info,
    output m_phv_ready,
    input  s_new_phv_ready, s_rtx_phv_ready,
    input  m_phv_valid, m_phv_info
  );
endinterface

// File: rtl/rbttx_phv_arbiter.sv
// Reliable-send TX PHV arbiter: merges freshly parsed PHVs ("new") with
// retransmit-engine replays ("rtx") into the single PHV stream of the TX MAU.
// Retransmissions win, but after MAX_RTX_BURST consecutive rtx grants while
// new traffic waits, one new PHV is forced through. Each output PHV carries
// the retransmit flag in bit RTX_FLAG_BIT. Output is a single register stage.
module rbttx_phv_arbiter #(
  parameter int PHV_WIDTH     = 408,
  parameter int RTX_FLAG_BIT  = 407,
  parameter int MAX_RTX_BURST = 4,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  rbttx_phv_arbiter_if.slave   phv,
  output logic [CNT_WIDTH-1:0] new_grant_cnt,
  output logic [CNT_WIDTH-1:0] rtx_grant_cnt
);

  localparam logic [7:0]           MAX_BURST_C = 8'(MAX_RTX_BURST);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX_C   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE_C   = CNT_WIDTH'(1);

  logic                 m_valid_r;
  logic [PHV_WIDTH-1:0] m_info_r;
  logic [7:0]           burst_cnt_r;
  logic [CNT_WIDTH-1:0] new_cnt_r;
  logic [CNT_WIDTH-1:0] rtx_cnt_r;

  logic load_en_s;
  logic starve_s;
  logic grant_rtx_s;
  logic grant_new_s;

  // Overwrite the retransmit flag bit, every other PHV bit passes unchanged.
  function automatic logic [PHV_WIDTH-1:0] apply_rtx_flag(
    input logic [PHV_WIDTH-1:0] info,
    input logic                 flag
  );
    logic [PHV_WIDTH-1:0] res;
    res               = info;
    res[RTX_FLAG_BIT] = flag;
    return res;
  endfunction

  // Grant selection: output slot free (or draining) and enabled; rtx has
  // priority unless new traffic has been passed over MAX_RTX_BURST times.
  // Nothing is accepted while reset is held.
  always_comb begin
    load_en_s   = 1'b0;
    starve_s    = 1'b0;
    grant_rtx_s = 1'b0;
    grant_new_s = 1'b0;
    if (!rst && enable && (!m_valid_r || phv.m_phv_ready)) begin
      load_en_s = 1'b1;
    end else begin
      load_en_s = 1'b0;
    end
    starve_s = phv.s_new_phv_valid && (burst_cnt_r == MAX_BURST_C);
    if (load_en_s) begin
      grant_rtx_s = phv.s_rtx_phv_valid && !starve_s;
      grant_new_s = phv.s_new_phv_valid && !(phv.s_rtx_phv_valid && !starve_s);
    end else begin
      grant_rtx_s = 1'b0;
      grant_new_s = 1'b0;
    end
  end

  assign phv.s_rtx_phv_ready = grant_rtx_s;
  assign phv.s_new_phv_ready = grant_new_s;
  assign phv.m_phv_valid     = m_valid_r;
  assign phv.m_phv_info      = m_info_r;
  assign new_grant_cnt       = new_cnt_r;
  assign rtx_grant_cnt       = rtx_cnt_r;

  // Output register: load on grant, clear once the held beat is taken,
  // otherwise hold valid and info stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_r <= 1'b0;
      m_info_r  <= '0;
    end else if (grant_rtx_s) begin
      m_valid_r <= 1'b1;
      m_info_r  <= apply_rtx_flag(phv.s_rtx_phv_info, 1'b1);
    end else if (grant_new_s) begin
      m_valid_r <= 1'b1;
      m_info_r  <= apply_rtx_flag(phv.s_new_phv_info, 1'b0);
    end else if (phv.m_phv_ready) begin
      m_valid_r <= 1'b0;
    end else begin
      m_valid_r <= m_valid_r;
    end
  end

  // Burst tracker: counts rtx grants that passed over a waiting new PHV.
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt_r <= 8'd0;
    end else if (grant_rtx_s && phv.s_new_phv_valid) begin
      if (burst_cnt_r < MAX_BURST_C) begin
        burst_cnt_r <= burst_cnt_r + 8'd1;
      end else begin
        burst_cnt_r <= burst_cnt_r;
      end
    end else if (grant_rtx_s || grant_new_s) begin
      burst_cnt_r <= 8'd0;
    end else begin
      burst_cnt_r <= burst_cnt_r;
    end
  end

  // Saturating grant statistics, one per source.
  always_ff @(posedge clk) begin
    if (rst) begin
      new_cnt_r <= '0;
      rtx_cnt_r <= '0;
    end else begin
      if (grant_new_s && (new_cnt_r != CNT_MAX_C)) begin
        new_cnt_r <= new_cnt_r + CNT_ONE_C;
      end else begin
        new_cnt_r <= new_cnt_r;
      end
      if (grant_rtx_s && (rtx_cnt_r != CNT_MAX_C)) begin
        rtx_cnt_r <= rtx_cnt_r + CNT_ONE_C;
      end else begin
        rtx_cnt_r <= rtx_cnt_r;
      end
    end
  end

endmodule
